// File: rtl/data_mem_resp_pkg.sv
// data_mem_resp_pkg: shared constants for the data-memory responder.
//   - region tags for the upper address half (RAM / MMIO)
//   - MMIO register addresses (LED, TXDATA, STATUS, CYCLE)
//   - STATUS register bit positions
//   - address decode helper returning a select enum
package data_mem_resp_pkg;

    localparam logic [15:0] RAM_TAG  = 16'h0000;
    localparam logic [15:0] MMIO_TAG = 16'hFFFF;

    localparam logic [31:0] ADDR_LED    = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0008;
    localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_000C;

    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_COUNT_LSB = 4;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_LED,
        SEL_TXDATA,
        SEL_STATUS,
        SEL_CYCLE,
        SEL_NONE
    } sel_e;

    // Word-aligned decode: addr[1:0] never participates.
    function automatic sel_e decode(input logic [31:0] addr);
        logic [31:0] word;
        word = {addr[31:2], 2'b00};
        if (addr[31:16] == RAM_TAG) return SEL_RAM;
        case (word)
            ADDR_LED:    return SEL_LED;
            ADDR_TXDATA: return SEL_TXDATA;
            ADDR_STATUS: return SEL_STATUS;
            ADDR_CYCLE:  return SEL_CYCLE;
            default:     return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_resp_sync_fifo.sv
// sync_fifo: single-clock FIFO, depth 2^AW, async active-high reset.
//   clk, rst      clock / asynchronous active-high reset
//   push, din     write strobe and data
//   pop           read strobe (ignored when empty)
//   dout          head entry, 0 when empty
//   full, empty   status flags
//   count         occupancy 0..DEPTH (AW+1 bits)
// Pop is evaluated first, so a push while full is accepted when a pop
// happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, wr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_C);
    assign count   = cnt_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem_q[rd_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push) wr_q <= wr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is not reset; dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: responder for the single-cycle core's data-memory port.
//   clk        system clock
//   reset      asynchronous active-high reset
//   mem_addr   byte address (word-aligned decode, [1:0] ignored)
//   mem_write  store data
//   mem_we     store strobe
//   mem_read   load data, combinational from mem_addr
//   leds       LED register
//   tx_data    TX FIFO head byte (0 when empty)
//   tx_valid   TX FIFO non-empty
//   tx_ready   consumer accepts head on tx_valid & tx_ready
// Map: 0x0000_xxxx RAM (aliases), 0xFFFF0000 LED, 0xFFFF0004 TXDATA,
//      0xFFFF0008 STATUS, 0xFFFF000C CYCLE.
// Build option: DMEM_CYCLE_CNT_EN adds the free-running CYCLE counter;
// without it CYCLE reads 0 and no counter flops exist.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write,
    input  logic        mem_we,
    output logic [31:0] mem_read,
    output logic [7:0]  leds,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    sel_e              sel;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram_q [2**RAM_AW];
    logic [7:0]        leds_q, leds_d;
    logic              ovf_q, ovf_d;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_AW:0]  fifo_count;
    logic [31:0]       status;
    logic [31:0]       cycle_val;
    logic              unused_addr_lsb;

    assign sel             = decode(mem_addr);
    assign ram_idx         = mem_addr[RAM_AW+1:2];
    assign unused_addr_lsb = ^mem_addr[1:0];

    assign fifo_pop  = tx_valid & tx_ready;
    assign fifo_push = mem_we & (sel == SEL_TXDATA);

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (mem_write[7:0]),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_valid = ~fifo_empty;

    always_ff @(posedge clk) begin
        if (mem_we && sel == SEL_RAM) ram_q[ram_idx] <= mem_write;
    end

    always_comb begin
        leds_d = leds_q;
        ovf_d  = ovf_q;
        if (mem_we && sel == SEL_LED) leds_d = mem_write[7:0];
        if (mem_we && sel == SEL_STATUS && mem_write[ST_OVF]) ovf_d = 1'b0;
        // Set after clear so a same-edge overflow wins.
        if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            leds_q <= leds_d;
            ovf_q  <= ovf_d;
        end
    end

    assign leds = leds_q;

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] cycle_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_q + 32'd1;
    end
    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    always_comb begin
        status                                = '0;
        status[ST_EMPTY]                      = fifo_empty;
        status[ST_FULL]                       = fifo_full;
        status[ST_OVF]                        = ovf_q;
        status[ST_COUNT_LSB +: FIFO_AW+1]     = fifo_count;
    end

    always_comb begin
        mem_read = '0;
        case (sel)
            SEL_RAM:    mem_read = ram_q[ram_idx];
            SEL_LED:    mem_read = {24'h0, leds_q};
            SEL_STATUS: mem_read = status;
            SEL_CYCLE:  mem_read = cycle_val;
            default:    mem_read = '0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;
    localparam int RAM_AW  = 10;
    localparam int FIFO_AW = 3;
    localparam int DEPTH   = 1 << FIFO_AW;

    localparam logic [31:0] A_LED    = 32'hFFFF_0000;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_write = '0;
    logic        mem_we = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] mem_read;
    logic [7:0]  leds;
    logic [7:0]  tx_data;
    logic        tx_valid;

    int n_tests = 0;
    int n_fail  = 0;

    data_mem_resp #(.RAM_AW(RAM_AW), .FIFO_AW(FIFO_AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_we    (mem_we),
        .mem_read  (mem_read),
        .leds      (leds),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    // Behavioural model
    logic [31:0] m_ram [int];
    logic [7:0]  m_leds = '0;
    logic [7:0]  m_q [$];
    bit          m_ovf = 1'b0;
    logic [31:0] m_cyc = '0;

    function automatic int ram_key(input logic [31:0] a);
        return int'((a >> 2) % (32'd1 << RAM_AW));
    endfunction

    function automatic logic [31:0] m_status();
        int sz;
        sz = m_q.size();
        return 32'(sz * 16 + (m_ovf ? 4 : 0) + (sz == DEPTH ? 2 : 0) + (sz == 0 ? 1 : 0));
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
        known = 1'b1;
        if (a[31:16] == 16'h0000) begin
            if (m_ram.exists(ram_key(a))) return m_ram[ram_key(a)];
            known = 1'b0;
            return '0;
        end
        case (a & ~32'h3)
            A_LED:    return {24'h0, m_leds};
            A_STATUS: return m_status();
`ifdef DMEM_CYCLE_CNT_EN
            A_CYCLE:  return m_cyc;
`endif
            default:  return '0;
        endcase
    endfunction

    task automatic m_reset();
        m_leds = '0;
        m_q.delete();
        m_ovf = 1'b0;
        m_cyc = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Compare all meaningful outputs against the model.
    task automatic check_model();
        bit known;
        logic [31:0] exp;
        exp = m_read(mem_addr, known);
        if (known) chk("model mem_read", mem_read, exp);
        chk("model leds", {24'h0, leds}, {24'h0, m_leds});
        chk("model tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() > 0});
        chk("model tx_data", {24'h0, tx_data}, {24'h0, (m_q.size() > 0) ? m_q[0] : 8'h00});
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic rdy);
        mem_addr  = a;
        mem_write = wd;
        mem_we    = we;
        tx_ready  = rdy;
        #1;
        check_model();
    endtask

    task automatic tick();
        bit pop, push;
        @(posedge clk);
        if (!reset) begin
            pop  = (m_q.size() > 0) && tx_ready;
            push = mem_we && ((mem_addr & ~32'h3) == A_TXDATA);
            if (mem_we && mem_addr[31:16] == 16'h0000) m_ram[ram_key(mem_addr)] = mem_write;
            if (mem_we && (mem_addr & ~32'h3) == A_LED) m_leds = mem_write[7:0];
            if (mem_we && (mem_addr & ~32'h3) == A_STATUS && mem_write[2]) m_ovf = 1'b0;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(mem_write[7:0]);
                else m_ovf = 1'b1;
            end
            m_cyc = m_cyc + 32'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] n;
        // Reset state
        #1;
        chk("reset leds", {24'h0, leds}, 32'h0);
        chk("reset tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("reset tx_data", {24'h0, tx_data}, 32'h0);
        mem_addr = A_STATUS;
        #1;
        chk("reset status", mem_read, 32'h1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // RAM round-trip, read-old-on-write, alias
        drive(32'h40, 32'h1111_1111, 1'b1, 1'b0); tick();
        drive(32'h40, 32'hDEAD_BEEF, 1'b1, 1'b0);
        chk("ram same-cycle old", mem_read, 32'h1111_1111);
        tick();
        drive(32'h40, 32'h0, 1'b0, 1'b0);
        chk("ram new value", mem_read, 32'hDEAD_BEEF);
        drive(32'h43, 32'h0, 1'b0, 1'b0);
        chk("ram addr lsb ignored", mem_read, 32'hDEAD_BEEF);
        drive(32'h40 + (32'd4 << RAM_AW), 32'h0, 1'b0, 1'b0);
        chk("ram alias", mem_read, 32'hDEAD_BEEF);
        tick();

        // LED and unmapped space
        drive(A_LED, 32'h1234_00A5, 1'b1, 1'b0); tick();
        drive(A_LED, 32'h0, 1'b0, 1'b0);
        chk("led read", mem_read, 32'h0000_00A5);
        chk("led port", {24'h0, leds}, 32'hA5);
        tick();
        drive(32'hFFFF_0010, 32'hFFFF_FFFF, 1'b1, 1'b0); tick();
        drive(32'hFFFF_0010, 32'h0, 1'b0, 1'b0);
        chk("unmapped read", mem_read, 32'h0);
        chk("unmapped no effect", {24'h0, leds}, 32'hA5);
        drive(A_TXDATA, 32'h0, 1'b0, 1'b0);
        chk("txdata reads 0", mem_read, 32'h0);
        tick();

        // FIFO fill past full
        for (int i = 1; i <= 8; i++) begin
            drive(A_TXDATA, 32'(i), 1'b1, 1'b0); tick();
        end
        drive(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("status full", mem_read, 32'h82);
        tick();
        drive(A_TXDATA, 32'h9, 1'b1, 1'b0); tick();
        drive(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("status overflow", mem_read, 32'h86);
        chk("head after overflow", {24'h0, tx_data}, 32'h01);
        tick();
        for (int i = 1; i <= 8; i++) begin
            drive(A_STATUS, 32'h0, 1'b0, 1'b1);
            chk($sformatf("drain byte %0d", i), {24'h0, tx_data}, 32'(i));
            tick();
        end
        drive(A_STATUS, 32'h0, 1'b0, 1'b1);
        chk("drained valid", {31'h0, tx_valid}, 32'h0);
        chk("status empty ovf", mem_read, 32'h05);
        tick();
        drive(A_STATUS, 32'h4, 1'b1, 1'b0); tick();
        drive(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("status ovf cleared", mem_read, 32'h01);
        tick();

        // Push and pop on same edge while full
        for (int i = 0; i < 8; i++) begin
            drive(A_TXDATA, 32'h11 + 32'(i), 1'b1, 1'b0); tick();
        end
        drive(A_TXDATA, 32'h19, 1'b1, 1'b1); tick();
        drive(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("full push+pop status", mem_read, 32'h82);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(A_STATUS, 32'h0, 1'b0, 1'b1);
            chk($sformatf("order byte %0d", i), {24'h0, tx_data}, 32'h12 + 32'(i));
            tick();
        end

        // Push and pop on same edge while empty
        drive(A_TXDATA, 32'h55, 1'b1, 1'b1);
        chk("empty push+pop valid", {31'h0, tx_valid}, 32'h0);
        tick();
        drive(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("empty push+pop status", mem_read, 32'h10);
        chk("empty push+pop head", {24'h0, tx_data}, 32'h55);
        tick();

        // Async reset with 3 bytes queued
        drive(A_TXDATA, 32'h66, 1'b1, 1'b0); tick();
        drive(A_TXDATA, 32'h77, 1'b1, 1'b0); tick();
        drive(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("pre-reset status", mem_read, 32'h30);
        #1 reset = 1'b1;
        #1;
        chk("async reset tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("async reset leds", {24'h0, leds}, 32'h0);
        chk("async reset status", mem_read, 32'h01);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(32'h40, 32'h0, 1'b0, 1'b0);
        chk("ram survives reset", mem_read, 32'hDEAD_BEEF);
        tick();

        // Cycle counter
        drive(A_CYCLE, 32'h0, 1'b0, 1'b0);
        n = mem_read;
        repeat (5) begin
            tick();
            drive(A_CYCLE, 32'hFFFF_FFFF, 1'b1, 1'b0);
        end
`ifdef DMEM_CYCLE_CNT_EN
        chk("cycle +5", mem_read, n + 32'd5);
`else
        chk("cycle absent", mem_read, 32'h0);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
